// File: rtl/fp_wb_queue_if.sv
// Bundle between the FP adder/multiplier, the FP writeback queue and the register-file write port.
// master = producers and register-file side, slave = the queue itself.
interface fp_wb_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          FADD_Done;
  logic [31:0]   FADD_Result;
  logic [3:0]    FADD_WA3;
  logic          FMUL_Done;
  logic [31:0]   FMUL_Result;
  logic [3:0]    FMUL_WA3;
  logic          WB_Ready;
  logic          WE3_FP;
  logic [3:0]    WA3_FP;
  logic [31:0]   WD3_FP;
  logic          Full;
  logic [CW-1:0] Count;
  logic          Overflow;

  // Handshake: an entry is written to the register file at an edge where WE3_FP && WB_Ready;
  // a Done pulse high at an edge enqueues its result regardless of any ready signal.
  modport master (
    output FADD_Done, FADD_Result, FADD_WA3,
    output FMUL_Done, FMUL_Result, FMUL_WA3,
    output WB_Ready,
    input  WE3_FP, WA3_FP, WD3_FP, Full, Count, Overflow
  );

  modport slave (
    input  FADD_Done, FADD_Result, FADD_WA3,
    input  FMUL_Done, FMUL_Result, FMUL_WA3,
    input  WB_Ready,
    output WE3_FP, WA3_FP, WD3_FP, Full, Count, Overflow
  );
endinterface

// File: rtl/fp_wb_queue.sv
// FIFO merging FP adder and multiplier results onto the single register-file FP write port.
// Optional macro FPWBQ_FWD_EN adds two read-address forwarding lookups into the queued entries.
module fp_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  fp_wb_queue_if.slave wb
`ifdef FPWBQ_FWD_EN
  ,
  input  logic [3:0]  RA1,
  input  logic [3:0]  RA2,
  output logic        FwdHit1,
  output logic [31:0] FwdData1,
  output logic        FwdHit2,
  output logic [31:0] FwdData2
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]    wa_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fmul_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          empty;
  logic          deq;
  logic [CW-1:0] free_slots;
  logic          acc_fadd;
  logic          acc_fmul;
  logic          drop;

  assign empty = (count == '0);
  assign deq   = !empty && wb.WB_Ready;

  // The slot freed by a same-edge dequeue is reusable, and FADD claims a slot before FMUL.
  always_comb begin
    free_slots = DEPTH_C - count + CW'(deq);
    acc_fadd   = wb.FADD_Done && (free_slots != '0);
    acc_fmul   = wb.FMUL_Done && (free_slots > CW'(acc_fadd));
    drop       = (wb.FADD_Done && !acc_fadd) || (wb.FMUL_Done && !acc_fmul);
    fmul_ptr   = acc_fadd ? wr_ptr + AW'(1) : wr_ptr;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (acc_fadd) begin
        wa_mem[wr_ptr] <= wb.FADD_WA3;
        wd_mem[wr_ptr] <= wb.FADD_Result;
      end
      if (acc_fmul) begin
        wa_mem[fmul_ptr] <= wb.FMUL_WA3;
        wd_mem[fmul_ptr] <= wb.FMUL_Result;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + AW'(deq);
      wr_ptr   <= wr_ptr + AW'(acc_fadd) + AW'(acc_fmul);
      count    <= count + CW'(acc_fadd) + CW'(acc_fmul) - CW'(deq);
      overflow <= overflow | drop;
    end
  end

  assign wb.WE3_FP   = !empty;
  assign wb.WA3_FP   = empty ? 4'h0 : wa_mem[rd_ptr];
  assign wb.WD3_FP   = empty ? 32'h0 : wd_mem[rd_ptr];
  assign wb.Full     = (count >= DEPTH_C - CW'(1));
  assign wb.Count    = count;
  assign wb.Overflow = overflow;

`ifdef FPWBQ_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the last valid match is the youngest one.
  always_comb begin
    FwdHit1  = 1'b0;
    FwdData1 = 32'h0;
    FwdHit2  = 1'b0;
    FwdData2 = 32'h0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if (wa_mem[fwd_idx] == RA1) begin
          FwdHit1  = 1'b1;
          FwdData1 = wd_mem[fwd_idx];
        end
        if (wa_mem[fwd_idx] == RA2) begin
          FwdHit2  = 1'b1;
          FwdData2 = wd_mem[fwd_idx];
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_fp_wb_queue.sv
// Directed bench for fp_wb_queue (DEPTH=4); expected FIFO contents held in a scoreboard queue.
module tb_fp_wb_queue;
  localparam int DEPTH = 4;

  logic CLK;
  logic Reset;

  fp_wb_queue_if #(.DEPTH(DEPTH)) wb ();

`ifdef FPWBQ_FWD_EN
  logic [3:0]  RA1, RA2;
  logic        FwdHit1, FwdHit2;
  logic [31:0] FwdData1, FwdData2;
`endif

  fp_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .wb       (wb.slave)
`ifdef FPWBQ_FWD_EN
    ,
    .RA1      (RA1),
    .RA2      (RA2),
    .FwdHit1  (FwdHit1),
    .FwdData1 (FwdData1),
    .FwdHit2  (FwdHit2),
    .FwdData2 (FwdData2)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock with the given completions and ready; checks the head if it is being written.
  task automatic cycle(input logic fa_v, input logic [3:0] fa_a, input logic [31:0] fa_d,
                       input logic fm_v, input logic [3:0] fm_a, input logic [31:0] fm_d,
                       input logic rdy);
    int   free;
    logic deq;
    wb.FADD_Done   = fa_v;
    wb.FADD_WA3    = fa_a;
    wb.FADD_Result = fa_d;
    wb.FMUL_Done   = fm_v;
    wb.FMUL_WA3    = fm_a;
    wb.FMUL_Result = fm_d;
    wb.WB_Ready    = rdy;
    deq = rdy && (exp_q.size() != 0);
    if (deq) begin
      chk("head_we", wb.WE3_FP, 1);
      chk("head_wa", wb.WA3_FP, exp_q[0][35:32]);
      chk("head_wd", wb.WD3_FP, exp_q[0][31:0]);
    end
    free = DEPTH - exp_q.size() + int'(deq);
    if (fa_v && free > 0) begin
      exp_q.push_back({fa_a, fa_d});
      free--;
    end
    if (fm_v && free > 0) exp_q.push_back({fm_a, fm_d});
    tick();
    if (deq) void'(exp_q.pop_front());
    wb.FADD_Done = 1'b0;
    wb.FMUL_Done = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, rdy);
  endtask

  task automatic fadd(input logic [3:0] a, input logic [31:0] d, input logic rdy);
    cycle(1'b1, a, d, 1'b0, 4'h0, 32'h0, rdy);
  endtask

  initial begin
    wb.FADD_Done = 1'b0; wb.FADD_Result = '0; wb.FADD_WA3 = '0;
    wb.FMUL_Done = 1'b0; wb.FMUL_Result = '0; wb.FMUL_WA3 = '0;
    wb.WB_Ready  = 1'b0;
`ifdef FPWBQ_FWD_EN
    RA1 = 4'h0; RA2 = 4'h0;
`endif
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;

    chk("rst_we", wb.WE3_FP, 0);
    chk("rst_wa", wb.WA3_FP, 0);
    chk("rst_wd", wb.WD3_FP, 0);
    chk("rst_full", wb.Full, 0);
    chk("rst_count", wb.Count, 0);
    chk("rst_ovf", wb.Overflow, 0);

    // single result: visible the cycle after Done, gone one cycle later
    fadd(4'd3, 32'h40400000, 1'b1);
    chk("lat_we", wb.WE3_FP, 1);
    chk("lat_wa", wb.WA3_FP, 3);
    chk("lat_wd", wb.WD3_FP, 32'h40400000);
    idle(1'b1);
    chk("lat_we_after", wb.WE3_FP, 0);
    chk("lat_count_after", wb.Count, 0);

    // same-cycle pair, FADD ahead of FMUL
    cycle(1'b1, 4'd1, 32'h3F800000, 1'b1, 4'd2, 32'h40000000, 1'b0);
    chk("pair_count", wb.Count, 2);
    chk("pair_full", wb.Full, 0);
    chk("pair_head_wa", wb.WA3_FP, 1);
    idle(1'b1);
    chk("pair_second_wa", wb.WA3_FP, 2);
    chk("pair_second_wd", wb.WD3_FP, 32'h40000000);
    idle(1'b1);
    chk("pair_drained", wb.Count, 0);

    // overflow: FMUL of the pair is dropped, flag is sticky
    fadd(4'd4, 32'hA0000004, 1'b0);
    fadd(4'd5, 32'hA0000005, 1'b0);
    fadd(4'd6, 32'hA0000006, 1'b0);
    chk("ovf_count3", wb.Count, 3);
    chk("ovf_full3", wb.Full, 1);
    chk("ovf_pre", wb.Overflow, 0);
    cycle(1'b1, 4'd7, 32'hA0000007, 1'b1, 4'd8, 32'hA0000008, 1'b0);
    chk("ovf_count4", wb.Count, 4);
    chk("ovf_flag", wb.Overflow, 1);
    chk("ovf_full4", wb.Full, 1);
    repeat (4) idle(1'b1);
    chk("ovf_drained", wb.Count, 0);
    chk("ovf_sticky", wb.Overflow, 1);

    // reset clears the flag and ignores a Done presented during reset
    Reset = 1'b1;
    wb.FADD_Done = 1'b1; wb.FADD_WA3 = 4'd9; wb.FADD_Result = 32'hDEADBEEF;
    tick();
    Reset = 1'b0;
    wb.FADD_Done = 1'b0;
    chk("rst2_ovf", wb.Overflow, 0);
    chk("rst2_count", wb.Count, 0);
    chk("rst2_we", wb.WE3_FP, 0);

    // full queue with simultaneous enqueue/dequeue; 10 entries wrap the pointers
    for (int i = 0; i < 4; i++) fadd(4'(i), 32'hC0DE0000 + 32'(i), 1'b0);
    chk("wrap_count_full", wb.Count, 4);
    for (int i = 4; i < 10; i++) begin
      fadd(4'(i), 32'hC0DE0000 + 32'(i), 1'b1);
      chk("wrap_count_hold", wb.Count, 4);
    end
    chk("wrap_no_ovf", wb.Overflow, 0);
    repeat (4) idle(1'b1);
    chk("wrap_drained", wb.Count, 0);

    // reset mid-operation discards queued entries
    fadd(4'd11, 32'h0000000B, 1'b0);
    fadd(4'd12, 32'h0000000C, 1'b0);
    fadd(4'd13, 32'h0000000D, 1'b0);
    chk("mid_count3", wb.Count, 3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    chk("mid_count", wb.Count, 0);
    chk("mid_we", wb.WE3_FP, 0);
    chk("mid_ovf", wb.Overflow, 0);
    chk("mid_wa", wb.WA3_FP, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("mid_no_write", wb.WE3_FP, 0);
    end

    // same destination twice: both written in order
    fadd(4'd5, 32'h11111111, 1'b0);
    fadd(4'd5, 32'h22222222, 1'b0);
    chk("dup_count", wb.Count, 2);
`ifdef FPWBQ_FWD_EN
    RA1 = 4'd5;
    RA2 = 4'd6;
    #1;
    chk("fwd_hit1", FwdHit1, 1);
    chk("fwd_data1", FwdData1, 32'h22222222);
    chk("fwd_hit2", FwdHit2, 0);
    chk("fwd_data2", FwdData2, 0);
`endif
    idle(1'b1);
    idle(1'b1);
    chk("dup_drained", wb.Count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_wb_queue.md
FP_WB_QUEUE -- requirements
Module: fp_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports FADD_Done in 1, FADD_Result in 32, FADD_WA3 in 4: FP-adder completion pulse, result word, destination register.
REQ-005 SHALL have ports FMUL_Done in 1, FMUL_Result in 32, FMUL_WA3 in 4: FP-multiplier completion pulse, result word, destination register.
REQ-006 SHALL have port WB_Ready  in  1  register-file FP write port is free this cycle.
REQ-007 SHALL have ports WE3_FP out 1, WA3_FP out 4, WD3_FP out 32: write enable, address and data to the register file.
REQ-008 SHALL have port Full  out  1  stall to FP issue; no new FADD/FMUL Start while high.
REQ-009 SHALL have port Count  out  log2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port Overflow  out  1  sticky error flag.

Function
REQ-011 Storage: circular buffer of DEPTH entries {WA3[3:0], data[31:0]}, with read pointer, write pointer and occupancy counter.
REQ-012 Enqueue: each Done pulse high at a clock edge writes one entry at that edge.
- Both Done high in one cycle: FADD entry at wr_ptr, FMUL at wr_ptr+1; write pointer advances by 2.
REQ-013 Head output is combinational from the head entry:
- WE3_FP = (Count != 0).
- WA3_FP/WD3_FP = head entry; both 0 when empty.
REQ-014 Dequeue: occurs at an edge where WE3_FP && WB_Ready; read pointer advances by 1.
REQ-015 Simultaneous enqueue(s) and dequeue in one cycle: Count_next = Count + enqueues - dequeue.
REQ-016 Latency: a result enqueued into an empty queue appears on WE3_FP the cycle after its Done edge; no same-cycle bypass.
REQ-017 Ordering: strict FIFO; same-cycle pair ordered FADD before FMUL.
REQ-018 Pointers wrap modulo DEPTH; Count ranges 0..DEPTH.
REQ-019 Full = (Count >= DEPTH-1), combinational, so two simultaneous completions always fit.
REQ-020 Enqueue attempted with insufficient free slots (accounting for same-cycle dequeue):
- excess entries dropped, FADD retained first;
- Overflow set and held until Reset;
- queue contents otherwise unchanged.
REQ-021 WB_Ready while empty: no effect; pointers unchanged.
REQ-022 Two queued entries with the same WA3: both written in order; the later one wins in the register file.

Reset
REQ-023 While Reset high at an edge:
- pointers, Count and Overflow cleared to 0;
- Done inputs ignored.
REQ-024 After reset: WE3_FP=0, WA3_FP=0, WD3_FP=0, Full=0, Count=0, Overflow=0.
REQ-025 Reset mid-operation discards all queued entries without writeback; entry storage need not be cleared.

Configuration
REQ-026 Macro FPWBQ_FWD_EN defined adds forwarding ports:
- RA1 in 4, RA2 in 4;
- FwdHit1 out 1, FwdData1 out 32, FwdHit2 out 1, FwdData2 out 32.
REQ-027 With FPWBQ_FWD_EN defined:
- FwdHitN = 1 when any valid entry's WA3 equals RAN, combinationally.
- FwdDataN = data of the youngest matching entry, else 0.
REQ-028 Without FPWBQ_FWD_EN: those ports and their comparators do not exist; all other behaviour identical.

Verification
REQ-029 Reset, then FADD_Done with WA3=3, Result=32'h40400000, WB_Ready=1 -> next cycle WE3_FP=1, WA3_FP=3, WD3_FP=32'h40400000; following cycle WE3_FP=0, Count=0.
REQ-030 WB_Ready=0; FADD(WA3=1, 32'h3F800000) and FMUL(WA3=2, 32'h40000000) in the same cycle -> Count=2, Full=0 (DEPTH=4); then WB_Ready=1 -> writes WA3=1 then WA3=2 on consecutive cycles.
REQ-031 WB_Ready=0; three single completions -> Count=3, Full=1; a fourth and fifth completion in one cycle -> FADD entry kept, FMUL dropped, Count=4, Overflow=1.
REQ-032 Count=4, one enqueue and one dequeue in the same cycle -> Count stays 4, no Overflow; pointers wrap past DEPTH-1 and FIFO order is preserved over 10 entries.
REQ-033 Count=3, Reset pulsed for one cycle -> next cycle Count=0, WE3_FP=0, Overflow=0; queued data never written.
REQ-034 FPWBQ_FWD_EN defined; queue holds WA3=5 (32'h11111111) then WA3=5 (32'h22222222); RA1=5, RA2=6 -> FwdHit1=1, FwdData1=32'h22222222, FwdHit2=0, FwdData2=0.
